mult_pipe_nxn: RTL

//   Parametrised soft multiplier. Generalises the fixed 9x9 hard multiplier with per-operand input registers.

---
 rtl/mult_pipe_pkg.sv | 30 +++
 rtl/mult_pipe_nxn_if.sv | 45 ++++
 rtl/mult_pipe_reg.sv | 40 ++++
 rtl/mult_pipe_nxn.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared types and sizing helpers for the parametrised pipelined multiplier.
// MULT_PIPE_ACC_EN turns the output register into an accumulator and widens z to ACC_WIDTH.
package mult_pipe_pkg;

    typedef enum logic {
        BYPASS   = 1'b0,
        REGISTER = 1'b1
    } reg_mode_e;

    localparam int MAX_MID_STAGES = 3;

`ifdef MULT_PIPE_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    function automatic int zw(input int a_w, input int b_w, input int acc_w);
        return ACC_EN ? acc_w : a_w + b_w;
    endfunction

    // The accumulator always occupies the output stage, whatever REG_OUT says.
    function automatic int lat(input int reg_in_a, input int reg_in_b,
                               input int mid_stages, input int reg_out);
        int in_stage;
        in_stage = (reg_in_a > reg_in_b) ? reg_in_a : reg_in_b;
        return in_stage + mid_stages + (ACC_EN ? 1 : reg_out);
    endfunction

endpackage

// File: rtl/mult_pipe_nxn_if.sv
// Operand, control and result bundle between a stimulus source and mult_pipe_nxn.
// acc_en/acc_ld exist only when MULT_PIPE_ACC_EN is defined.
interface mult_pipe_nxn_if #(
    parameter int A_WIDTH = 9,
    parameter int B_WIDTH = 9,
    parameter int ZW      = 18
);
    logic               strobe;
    logic               cea;
    logic               ceb;
    logic               rsta;
    logic               rstb;
    logic               ceo;
    logic               rsto;
    logic               a_signed;
    logic               b_signed;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic               in_valid;
    logic [ZW-1:0]      z;
    logic               out_valid;
`ifdef MULT_PIPE_ACC_EN
    logic               acc_en;
    logic               acc_ld;
`endif

    modport master (
        output strobe, cea, ceb, rsta, rstb, ceo, rsto,
        output a_signed, b_signed, a, b, in_valid,
`ifdef MULT_PIPE_ACC_EN
        output acc_en, acc_ld,
`endif
        input  z, out_valid
    );

    modport slave (
        input  strobe, cea, ceb, rsta, rstb, ceo, rsto,
        input  a_signed, b_signed, a, b, in_valid,
`ifdef MULT_PIPE_ACC_EN
        input  acc_en, acc_ld,
`endif
        output z, out_valid
    );

endinterface

// File: rtl/mult_pipe_reg.sv
// One pipeline register: async clear, strobe-gated sync clear (wins over CE), strobe-gated load.
// With EN = BYPASS it collapses to a wire and its control pins are ignored.
module mult_pipe_reg
    import mult_pipe_pkg::*;
#(
    parameter int        W  = 1,
    parameter reg_mode_e EN = REGISTER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         strobe,
    input  logic         ce,
    input  logic         srst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (EN == REGISTER) begin : g_reg
            logic [W-1:0] q_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r <= '0;
                end else if (strobe && srst) begin
                    q_r <= '0;
                end else if (strobe && ce) begin
                    q_r <= d;
                end
            end

            assign q = q_r;
        end else begin : g_byp
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, strobe, ce, srst};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/mult_pipe_nxn.sv
// Parametrised signed/unsigned multiplier: optional input regs, 0..3 product stages, optional output reg.
// Latency L strobe steps; no backpressure, strobe low freezes every stage. MULT_PIPE_ACC_EN adds an accumulator.
module mult_pipe_nxn
    import mult_pipe_pkg::*;
#(
    parameter int A_WIDTH    = 9,
    parameter int B_WIDTH    = 9,
    parameter int REG_IN_A   = 1,
    parameter int REG_IN_B   = 1,
    parameter int MID_STAGES = 0,
    parameter int REG_OUT    = 0,
    parameter int ACC_WIDTH  = 48
) (
    input logic           clk,
    input logic           rst,
    mult_pipe_nxn_if.slave bus
);

    localparam int ZW = zw(A_WIDTH, B_WIDTH, ACC_WIDTH);
    localparam int L  = lat(REG_IN_A, REG_IN_B, MID_STAGES, REG_OUT);

    // Signed flag rides in the MSB so it shares its operand's CE and reset.
    logic [A_WIDTH:0] a_q;
    logic [B_WIDTH:0] b_q;

    mult_pipe_reg #(.W(A_WIDTH + 1), .EN(REG_IN_A != 0 ? REGISTER : BYPASS)) u_reg_a (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.strobe),
        .ce     (bus.cea),
        .srst   (bus.rsta),
        .d      ({bus.a_signed, bus.a}),
        .q      (a_q)
    );

    mult_pipe_reg #(.W(B_WIDTH + 1), .EN(REG_IN_B != 0 ? REGISTER : BYPASS)) u_reg_b (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.strobe),
        .ce     (bus.ceb),
        .srst   (bus.rstb),
        .d      ({bus.b_signed, bus.b}),
        .q      (b_q)
    );

    logic signed [A_WIDTH:0] a_ext;
    logic signed [B_WIDTH:0] b_ext;
    logic signed [ZW-1:0]    prod;

    // Only the low ZW bits are ever kept, so multiplying at width ZW is exact modulo 2^ZW.
    assign a_ext = {a_q[A_WIDTH] & a_q[A_WIDTH-1], a_q[A_WIDTH-1:0]};
    assign b_ext = {b_q[B_WIDTH] & b_q[B_WIDTH-1], b_q[B_WIDTH-1:0]};
    assign prod  = ZW'(a_ext) * ZW'(b_ext);

    logic [MID_STAGES:0][ZW-1:0] stage;
    assign stage[0] = prod;

    for (genvar i = 0; i < MID_STAGES; i++) begin : g_mid
        mult_pipe_reg #(.W(ZW), .EN(REGISTER)) u_reg_mid (
            .clk    (clk),
            .rst    (rst),
            .strobe (bus.strobe),
            .ce     (bus.ceo),
            .srst   (bus.rsto),
            .d      (stage[i]),
            .q      (stage[i+1])
        );
    end

    logic [ZW-1:0] z_q;

`ifdef MULT_PIPE_ACC_EN
    logic [ZW-1:0] acc_d;
    logic          acc_ce;

    // acc_ld beats acc_en; rsto beats both through the register's sync-clear priority.
    always_comb begin
        acc_d  = bus.acc_ld ? stage[MID_STAGES] : z_q + stage[MID_STAGES];
        acc_ce = bus.ceo & (bus.acc_ld | bus.acc_en);
    end

    mult_pipe_reg #(.W(ZW), .EN(REGISTER)) u_reg_out (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.strobe),
        .ce     (acc_ce),
        .srst   (bus.rsto),
        .d      (acc_d),
        .q      (z_q)
    );
`else
    mult_pipe_reg #(.W(ZW), .EN(REG_OUT != 0 ? REGISTER : BYPASS)) u_reg_out (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.strobe),
        .ce     (bus.ceo),
        .srst   (bus.rsto),
        .d      (stage[MID_STAGES]),
        .q      (z_q)
    );
`endif

    assign bus.z = z_q;

    generate
        if (L == 0) begin : g_vld_byp
            assign bus.out_valid = bus.in_valid;
        end else begin : g_vld_pipe
            logic [L-1:0] vld_sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_sr <= '0;
                end else if (bus.strobe) begin
                    vld_sr <= bus.rsto ? '0 : L'({vld_sr, bus.in_valid});
                end
            end

            assign bus.out_valid = vld_sr[L-1];
        end
    endgenerate

endmodule
